// File: rtl/ndn_pkg.sv
// ndn_pkg: shared widths, op encoding and name masking helper for the name table.
package ndn_pkg;
  localparam int NAME_W = 64;
  localparam int LEN_W = 6;
  localparam int IDX_W = 10;
  localparam logic OP_LOOKUP = 1'b0;
  localparam logic OP_INSERT = 1'b1;
  function automatic logic [NAME_W-1:0] mask_name(input logic [NAME_W-1:0] name, input logic [LEN_W-1:0] len);
    return name & ((NAME_W'(1) << len) - NAME_W'(1));
  endfunction
endpackage

// File: rtl/name_table_ram.sv
// name_table_ram: 1024 x {len,name} storage with one synchronous read and one write port.
module name_table_ram
  import ndn_pkg::*;
(
  input  logic                    clk,
  input  logic [IDX_W-1:0]        raddr,
  output logic [LEN_W+NAME_W-1:0] rdata,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [LEN_W+NAME_W-1:0] wdata
);
  logic [LEN_W+NAME_W-1:0] mem [2**IDX_W];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/name_table_lookup.sv
// name_table_lookup: linear-probing name table with LOOKUP/INSERT requests.
module name_table_lookup
  import ndn_pkg::*;
#(
  parameter int MAX_PROBE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [NAME_W-1:0] req_name,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [IDX_W-1:0]  req_hash,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_full,
  output logic [IDX_W-1:0]  rsp_index
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  logic [1:0] state;
  logic op_q, vld_q, hit_q, full_q;
  logic [NAME_W-1:0] name_q;
  logic [LEN_W-1:0] len_q;
  logic [IDX_W-1:0] hash_q, idx_q, addr;
  logic [4:0] probe;
  logic [2**IDX_W-1:0] valid;
  logic [LEN_W+NAME_W-1:0] rd_data;
  logic match, last, done, we;
  assign addr = hash_q + IDX_W'(probe);
  assign match = vld_q && rd_data == {len_q, name_q};
  assign last = probe == 5'(MAX_PROBE - 1);
  assign done = match || !vld_q || last;
  // a reset landing in COMPARE must not commit the pending insert
  assign we = state == COMPARE && !rst && op_q == OP_INSERT && !vld_q;
  assign req_ready = state == IDLE && !rst;
  assign rsp_valid = state == RESP && !rst;
  assign rsp_hit = hit_q && !rst;
  assign rsp_full = full_q && !rst;
  assign rsp_index = rst ? '0 : idx_q;
  name_table_ram u_ram (
    .clk(clk),
    .raddr(addr),
    .rdata(rd_data),
    .we(we),
    .waddr(addr),
    .wdata({len_q, name_q})
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      hit_q <= 1'b0;
      full_q <= 1'b0;
      idx_q <= '0;
      probe <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q <= req_op;
          name_q <= mask_name(req_name, req_len);
          len_q <= req_len;
          hash_q <= req_hash;
          probe <= '0;
          state <= READ;
        end
        READ: begin
          vld_q <= valid[addr];
          state <= COMPARE;
        end
        COMPARE: if (done) begin
          hit_q <= match;
          full_q <= vld_q && !match && op_q == OP_INSERT;
          idx_q <= (match || we) ? addr : '0;
          if (we) valid[addr] <= 1'b1;
          state <= RESP;
        end else begin
          probe <= probe + 5'd1;
          state <= READ;
        end
        default: if (rsp_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_name_table_lookup.sv
// tb_name_table_lookup: directed and randomized checks of name_table_lookup against a table model.
module tb_name_table_lookup;
  localparam int MAX = 4;
  logic clk = 0, rst = 1, req_valid = 0, req_op = 0, rsp_ready = 0;
  logic [63:0] req_name = '0;
  logic [5:0] req_len = '0;
  logic [9:0] req_hash = '0;
  logic req_ready, rsp_valid, rsp_hit, rsp_full;
  logic [9:0] rsp_index;
  bit m_valid [1024];
  logic [5:0] m_len [1024];
  logic [63:0] m_name [1024];
  int n_cmp = 0, n_bad = 0;

  name_table_lookup #(.MAX_PROBE(MAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_name(req_name), .req_len(req_len), .req_hash(req_hash), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_full(rsp_full), .rsp_index(rsp_index)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 0;
  endtask

  task automatic model(input bit op, input logic [63:0] name, input logic [5:0] len, input logic [9:0] hash,
                       output bit hit, output bit full, output logic [9:0] idx, output int probes);
    logic [63:0] mn = '0;
    bit found = 0;
    for (int i = 0; i < int'(len); i++) mn[i] = name[i];
    hit = 0; full = 0; idx = 0; probes = MAX;
    for (int p = 0; p < MAX; p++) begin
      int s = (int'(hash) + p) % 1024;
      if (!found && m_valid[s] && m_len[s] == len && m_name[s] == mn) begin
        hit = 1; idx = 10'(s); probes = p + 1; found = 1;
      end else if (!found && !m_valid[s]) begin
        if (op) begin
          m_valid[s] = 1; m_len[s] = len; m_name[s] = mn; idx = 10'(s);
        end
        probes = p + 1; found = 1;
      end
    end
    if (!found && op) full = 1;
  endtask

  // phase convention: the bench always resumes 1 time unit after a rising edge
  task automatic drive(input bit op, input logic [63:0] name, input logic [5:0] len, input logic [9:0] hash,
                       input int hold, output bit hit, output bit full, output logic [9:0] idx,
                       output int lat, output bit stable);
    int t = 0;
    while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
    req_valid = 1; req_op = op; req_name = name; req_len = len; req_hash = hash;
    @(posedge clk); #1;
    req_valid = 0; req_name = $urandom; lat = 0;
    while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    hit = rsp_hit; full = rsp_full; idx = rsp_index; stable = 1;
    repeat (hold) begin
      if (req_ready) stable = 0;
      @(posedge clk); #1;
      if (rsp_valid !== 1 || rsp_hit !== hit || rsp_full !== full || rsp_index !== idx) stable = 0;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  task automatic txn(input bit op, input logic [63:0] name, input logic [5:0] len, input logic [9:0] hash,
                     input int hold, output bit e_hit, output bit e_full, output logic [9:0] e_idx,
                     output int e_lat, output bit hit, output bit full, output logic [9:0] idx,
                     output int lat, output bit stable);
    int probes;
    model(op, name, len, hash, e_hit, e_full, e_idx, probes);
    e_lat = 2 * probes;
    drive(op, name, len, hash, hold, hit, full, idx, lat, stable);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_hit, rsp_full, rsp_index} !== 14'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 0", {req_ready, rsp_valid, rsp_hit, rsp_full, rsp_index});
    end
    rst = 0;
    model_clear();
    #1;
    n_cmp++;
    if (req_ready !== 1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_lookup_empty();
    bit eh, ef, h, f, st; logic [9:0] ei, i; int el, l;
    txn(0, 64'hAB, 6'd8, 10'h155, 0, eh, ef, ei, el, h, f, i, l, st);
    n_cmp++;
    if ({h, f, i} !== 12'd0) begin n_bad++; $display("FAIL lookup_empty: got hit=%b full=%b idx=%h want 0/0/000", h, f, i); end
    n_cmp++;
    if (l !== 2) begin n_bad++; $display("FAIL lookup_empty_lat: got %0d want 2", l); end
  endtask

  task automatic test_insert_lookup();
    bit eh, ef, h, f, st; logic [9:0] ei, i; int el, l;
    txn(1, 64'h1234, 6'd16, 10'h010, 0, eh, ef, ei, el, h, f, i, l, st);
    n_cmp++;
    if ({h, f, i} !== {2'b00, 10'h010}) begin n_bad++; $display("FAIL insert: got hit=%b full=%b idx=%h want 0/0/010", h, f, i); end
    txn(0, 64'h1234, 6'd16, 10'h010, 0, eh, ef, ei, el, h, f, i, l, st);
    n_cmp++;
    if ({h, f, i} !== {2'b10, 10'h010}) begin n_bad++; $display("FAIL lookup_after_insert: got hit=%b full=%b idx=%h want 1/0/010", h, f, i); end
    txn(1, 64'h1234, 6'd16, 10'h010, 0, eh, ef, ei, el, h, f, i, l, st);
    n_cmp++;
    if ({h, f, i} !== {2'b10, 10'h010}) begin n_bad++; $display("FAIL insert_existing: got hit=%b full=%b idx=%h want 1/0/010", h, f, i); end
  endtask

  task automatic test_masking();
    bit eh, ef, h, f, st; logic [9:0] ei, i; int el, l;
    txn(1, 64'hFF00_0000_0000_00AB, 6'd8, 10'h100, 0, eh, ef, ei, el, h, f, i, l, st);
    txn(0, 64'h0000_0000_0000_00AB, 6'd8, 10'h100, 0, eh, ef, ei, el, h, f, i, l, st);
    n_cmp++;
    if ({h, i} !== {1'b1, 10'h100}) begin n_bad++; $display("FAIL mask_hit: got hit=%b idx=%h want 1/100", h, i); end
    txn(0, 64'h0000_0000_0000_00AB, 6'd9, 10'h100, 0, eh, ef, ei, el, h, f, i, l, st);
    n_cmp++;
    if ({h, f, i} !== 12'd0) begin n_bad++; $display("FAIL mask_len9: got hit=%b full=%b idx=%h want 0/0/000", h, f, i); end
  endtask

  task automatic test_collision_wrap();
    bit eh, ef, h, f, st; logic [9:0] ei, i; int el, l;
    logic [9:0] want [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    for (int k = 0; k < 4; k++) begin
      txn(1, 64'hC0 + 64'(k), 6'd12, 10'h3FE, 0, eh, ef, ei, el, h, f, i, l, st);
      n_cmp++;
      if ({h, f, i} !== {2'b00, want[k]} || l !== 2 * (k + 1)) begin
        n_bad++; $display("FAIL collide_%0d: got hit=%b full=%b idx=%h lat=%0d want 0/0/%h lat=%0d", k, h, f, i, l, want[k], 2 * (k + 1));
      end
    end
    txn(1, 64'hC4, 6'd12, 10'h3FE, 0, eh, ef, ei, el, h, f, i, l, st);
    n_cmp++;
    if ({h, f, i} !== {2'b01, 10'h000} || l !== 8) begin n_bad++; $display("FAIL collide_full: got hit=%b full=%b idx=%h lat=%0d want 0/1/000 lat=8", h, f, i, l); end
    txn(0, 64'hC3, 6'd12, 10'h3FE, 0, eh, ef, ei, el, h, f, i, l, st);
    n_cmp++;
    if ({h, f, i} !== {2'b10, 10'h001} || l !== 8) begin n_bad++; $display("FAIL collide_lookup: got hit=%b full=%b idx=%h lat=%0d want 1/0/001 lat=8", h, f, i, l); end
  endtask

  task automatic test_backpressure();
    bit eh, ef, h, f, st; logic [9:0] ei, i; int el, l;
    txn(1, 64'h5A5A, 6'd16, 10'h200, 5, eh, ef, ei, el, h, f, i, l, st);
    n_cmp++;
    if (st !== 1) begin n_bad++; $display("FAIL backpressure_stable: got %b want 1", st); end
    n_cmp++;
    if ({h, f, i} !== {2'b00, 10'h200}) begin n_bad++; $display("FAIL backpressure_rsp: got hit=%b full=%b idx=%h want 0/0/200", h, f, i); end
  endtask

  task automatic test_random();
    bit eh, ef, h, f, st; logic [9:0] ei, i; int el, l;
    logic [63:0] pool [6] = '{64'h1, 64'h3F, 64'hABCD, 64'hFFFF_0001, 64'h8000_0000_0000_0005, 64'h7};
    for (int k = 0; k < 60; k++) begin
      bit op = 1'($urandom);
      logic [63:0] nm = pool[$urandom_range(0, 5)];
      logic [5:0] ln = 6'($urandom_range(0, 12));
      logic [9:0] hs = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'h080 + 10'($urandom_range(0, 3));
      txn(op, nm, ln, hs, $urandom_range(0, 2), eh, ef, ei, el, h, f, i, l, st);
      n_cmp++;
      if ({h, f, i} !== {eh, ef, ei} || l !== el || st !== 1) begin
        n_bad++; $display("FAIL random_%0d: got hit=%b full=%b idx=%h lat=%0d stable=%b want %b/%b/%h lat=%0d", k, h, f, i, l, st, eh, ef, ei, el);
      end
    end
  endtask

  task automatic test_reset_mid_insert();
    bit eh, ef, h, f, st; logic [9:0] ei, i; int el, l;
    bit seen = 0;
    while (!req_ready) begin @(posedge clk); #1; end
    req_valid = 1; req_op = 1; req_name = 64'h7777; req_len = 6'd20; req_hash = 10'h020;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_hit, rsp_full, rsp_index} !== 14'd0) begin
      n_bad++; $display("FAIL midreset_outputs: got %b want 0", {req_ready, rsp_valid, rsp_hit, rsp_full, rsp_index});
    end
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    repeat (4) begin if (rsp_valid) seen = 1; @(posedge clk); #1; end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL midreset_no_rsp: got rsp_valid=1 want 0"); end
    txn(0, 64'h7777, 6'd20, 10'h020, 0, eh, ef, ei, el, h, f, i, l, st);
    n_cmp++;
    if ({h, f, i} !== 12'd0) begin n_bad++; $display("FAIL midreset_lookup: got hit=%b full=%b idx=%h want 0/0/000", h, f, i); end
  endtask

  initial begin
    test_reset();
    test_lookup_empty();
    test_insert_lookup();
    test_masking();
    test_collision_wrap();
    test_backpressure();
    test_random();
    test_reset_mid_insert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
